// File: rtl/multi_cycle_mips.sv
// multi_cycle_mips: multi-cycle MIPS-subset core (IF/ID/EX/MEM/WB) tolerating wait-stated memories; define IMM_LOGIC_EN to add andi/ori/slti/lui
module multi_cycle_mips #(
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        IR_addr,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [31:0]        IR,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        Data2Mem,
  input  logic [31:0]        ReadDataMem,
  input  logic               dmem_ready,
  output logic               retire
);
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  logic [2:0] state, state_nx;
  logic [31:0] pc_r, ir_r, a_r, b_r, alu_r, mdr_r, sext, imm_res, alu_res;
  logic [31:0] rf [32];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt, wd;
  logic is_r, is_alu_r, is_jr, is_lw, is_sw, is_j, is_jal, is_imm, wb_path, mem_op, taken;
  assign op       = ir_r[31:26];
  assign rs       = ir_r[25:21];
  assign rt       = ir_r[20:16];
  assign rd       = ir_r[15:11];
  assign shamt    = ir_r[10:6];
  assign funct    = ir_r[5:0];
  assign sext     = {{16{ir_r[15]}}, ir_r[15:0]};
  assign is_r     = op == 6'h00;
  assign is_alu_r = is_r && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02});
  assign is_jr    = is_r && funct == 6'h08;
  assign is_lw    = op == 6'h23;
  assign is_sw    = op == 6'h2b;
  assign is_j     = op == 6'h02;
  assign is_jal   = op == 6'h03;
  assign taken    = (op == 6'h04 && a_r == b_r) || (op == 6'h05 && a_r != b_r);
`ifdef IMM_LOGIC_EN
  logic [31:0] zext;
  assign zext    = {16'h0, ir_r[15:0]};
  assign is_imm  = op inside {6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f};
  assign imm_res = op == 6'h0c ? a_r & zext :
                   op == 6'h0d ? a_r | zext :
                   op == 6'h0a ? {31'b0, $signed(a_r) < $signed(sext)} :
                   op == 6'h0f ? {ir_r[15:0], 16'h0} : a_r + sext;
`else
  assign is_imm  = op == 6'h08;
  assign imm_res = a_r + sext;
`endif
  assign wb_path  = is_alu_r || is_imm;
  assign mem_op   = is_lw || is_sw;
  assign wd       = is_r ? rd : rt;
  assign IR_addr  = pc_r;
  assign imem_req = rst_n && state == S_IF;
  assign CEN      = state != S_MEM;
  assign WEN      = !(state == S_MEM && is_sw);
  assign OEN      = !(state == S_MEM && is_lw);
  assign A        = alu_r[DMEM_AW+1:2];
  assign Data2Mem = b_r;
  // a store finishes in MEM, so its retire is qualified by the data handshake
  assign retire   = state == S_WB || (state == S_EX && !wb_path && !mem_op) ||
                    (state == S_MEM && is_sw && dmem_ready);
  // ALU result: R-type by funct, otherwise the immediate path (also the lw/sw address)
  always_comb begin
    alu_res = !is_r           ? imm_res :
              funct == 6'h20  ? a_r + b_r :
              funct == 6'h22  ? a_r - b_r :
              funct == 6'h24  ? a_r & b_r :
              funct == 6'h25  ? a_r | b_r :
              funct == 6'h2a  ? {31'b0, $signed(a_r) < $signed(b_r)} :
              funct == 6'h00  ? b_r << shamt : b_r >> shamt;
  end
  // FSM transitions, stalling in IF and MEM until the memory handshakes
  always_comb begin
    state_nx = state == S_IF  ? (imem_ready ? S_ID : S_IF) :
               state == S_ID  ? S_EX :
               state == S_EX  ? (wb_path ? S_WB : mem_op ? S_MEM : S_IF) :
               state == S_MEM ? (dmem_ready ? (is_lw ? S_WB : S_IF) : S_MEM) : S_IF;
  end
  // architectural state: stage registers, PC and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IF;
      pc_r  <= RESET_PC;
      ir_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      alu_r <= '0;
      mdr_r <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IF: if (imem_ready) begin
          ir_r <= IR;
          pc_r <= pc_r + 32'd4;
        end
        S_ID: begin
          a_r <= rf[rs];
          b_r <= rf[rt];
        end
        S_EX: begin
          alu_r <= alu_res;
          if (taken) pc_r <= pc_r + {sext[29:0], 2'b00};
          if (is_j || is_jal) pc_r <= {pc_r[31:28], ir_r[25:0], 2'b00};
          if (is_jal) rf[31] <= pc_r;
          if (is_jr) pc_r <= a_r;
        end
        S_MEM: if (dmem_ready && is_lw) mdr_r <= ReadDataMem;
        S_WB: if (wd != 5'd0) rf[wd] <= is_lw ? mdr_r : alu_r;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_mips.sv
// tb_multi_cycle_mips: directed and random instruction sequences checked against an ISA-level model
module tb_multi_cycle_mips;
  logic clk = 0, rst_n = 0;
  logic [31:0] IR_addr, IR, Data2Mem, ReadDataMem;
  logic imem_req, imem_ready, CEN, WEN, OEN, dmem_ready, retire;
  logic [6:0] A;
  multi_cycle_mips dut (
    .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .imem_req(imem_req), .imem_ready(imem_ready),
    .IR(IR), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem), .dmem_ready(dmem_ready), .retire(retire)
  );
  always #5 clk = ~clk;

  int passed = 0, failed = 0, total = 0;
  int iwait = 0, dwait = 0, icnt, dcnt, wcount = 0;
  logic [31:0] imem [1024];
  logic [31:0] dmem [128];
  logic [127:0] dwr = '0;
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [128];
  logic [31:0] m_pc, st_data;
  logic [6:0] st_addr;
  logic [5:0] alu_fn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
  logic [5:0] nop_op [6] = '{6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h3f, 6'h01};

  function automatic logic [31:0] init_pat(input logic [6:0] a);
    return 32'hC0DE0000 + 32'(a) * 32'h00010003;
  endfunction

  assign IR          = imem[IR_addr[11:2]];
  assign imem_ready  = imem_req && icnt >= iwait;
  assign dmem_ready  = !CEN && dcnt >= dwait;
  assign ReadDataMem = dwr[A] ? dmem[A] : init_pat(A);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
      dcnt <= (!CEN && !dmem_ready) ? dcnt + 1 : 0;
    end

  always @(posedge clk)
    if (rst_n && !CEN && !WEN && dmem_ready) begin
      dmem[A] <= Data2Mem;
      dwr[A]  <= 1'b1;
      wcount  <= wcount + 1;
    end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd, rs, rt, sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Executes one instruction in the ISA model, runs it on the DUT from its first IF cycle, and compares.
  task automatic step(input logic [31:0] ins, input int iw, input int dw);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    logic [31:0] a, b, simm, npc, wv, addr;
    int wr, lat, n, wen_c, oen_c;
    bit is_sw, is_lw;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a = m_rf[rs]; b = m_rf[rt]; simm = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 4; addr = a + simm; wr = 0; wv = 0; lat = 3; is_sw = 0; is_lw = 0;
    if (op == 6'h00) begin
      wr = rd; lat = 4;
      case (fn)
        6'h20: wv = a + b;
        6'h22: wv = a - b;
        6'h24: wv = a & b;
        6'h25: wv = a | b;
        6'h2a: wv = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h00: wv = b << sh;
        6'h02: wv = b >> sh;
        6'h08: begin npc = a; wr = 0; lat = 3; end
        default: begin wr = 0; lat = 3; end
      endcase
    end else case (op)
      6'h08: begin wr = rt; wv = a + simm; lat = 4; end
      6'h23: begin is_lw = 1; wr = rt; wv = m_mem[addr[8:2]]; lat = 5; end
      6'h2b: begin is_sw = 1; lat = 4; end
      6'h04: if (a == b) npc = npc + simm * 4;
      6'h05: if (a != b) npc = npc + simm * 4;
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin npc = {npc[31:28], ins[25:0], 2'b00}; wr = 31; wv = m_pc + 4; end
`ifdef IMM_LOGIC_EN
      6'h0c: begin wr = rt; wv = a & {16'h0, ins[15:0]}; lat = 4; end
      6'h0d: begin wr = rt; wv = a | {16'h0, ins[15:0]}; lat = 4; end
      6'h0a: begin wr = rt; wv = ($signed(a) < $signed(simm)) ? 1 : 0; lat = 4; end
      6'h0f: begin wr = rt; wv = {ins[15:0], 16'h0}; lat = 4; end
`endif
      default: ;
    endcase
    lat = lat + iw + ((is_lw || is_sw) ? dw : 0);
    iwait = iw; dwait = dw; imem[m_pc[11:2]] = ins;
    n = 1; wen_c = 0; oen_c = 0;
    forever begin
      if (!WEN) wen_c++;
      if (!OEN) oen_c++;
      if (retire || n >= 200) break;
      @(posedge clk); #1;
      n++;
    end
    check("retire", retire, 1);
    check("latency", n, lat);
    check("wen_cycles", wen_c, is_sw ? dw + 1 : 0);
    check("oen_cycles", oen_c, is_lw ? dw + 1 : 0);
    if (is_sw) begin
      check("sw_addr", A, addr[8:2]);
      check("sw_data", Data2Mem, b);
      st_data = Data2Mem; st_addr = A;
      m_mem[addr[8:2]] = b;
    end
    if (wr != 0) m_rf[wr] = wv;
    m_pc = npc;
    @(posedge clk); #1;
    check("next_pc", IR_addr, m_pc);
    check("imem_req", imem_req, 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_pc = 0;
  endtask

  initial begin
    int sel, wc0, n;
    logic [4:0] r1, r2, r3;
    logic [31:0] ins;
    for (int i = 0; i < 1024; i++) imem[i] = 0;
    for (int i = 0; i < 128; i++) m_mem[i] = init_pat(7'(i));
    model_reset();
    #3;
    check("rst_imem_req", imem_req, 0);
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_oen", OEN, 1);
    check("rst_ir_addr", IR_addr, 0);
    check("rst_a", A, 0);
    check("rst_data", Data2Mem, 0);
    check("rst_retire", retire, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 check("rel_imem_req", imem_req, 1);

    step(enc_i(6'h08, 1, 0, 16'd5), 0, 0);
    step(enc_i(6'h08, 2, 0, 16'hFFFD), 0, 0);
    step(enc_r(6'h20, 3, 1, 2, 0), 0, 0);
    step(enc_i(6'h2b, 3, 0, 16'd0), 0, 0);
    check("t1_r3", st_data, 32'd2);

    step(enc_i(6'h2b, 1, 0, 16'd8), 0, 2);
    check("t2_a", st_addr, 7'd2);
    step(enc_i(6'h23, 4, 0, 16'd8), 0, 2);
    step(enc_i(6'h2b, 4, 0, 16'd16), 1, 0);
    check("t2_r4", st_data, 32'd5);

    step(enc_j(6'h02, 26'h4), 0, 0);
    check("t3_j", IR_addr, 32'h10);
    step(enc_i(6'h04, 1, 1, 16'hFFFF), 0, 0);
    check("t3_beq", IR_addr, 32'h10);
    step(enc_i(6'h05, 1, 1, 16'd4), 2, 0);
    check("t3_bne", IR_addr, 32'h14);

    step(enc_j(6'h02, 26'h8), 0, 0);
    step(enc_j(6'h03, 26'h40), 0, 0);
    check("t4_jal", IR_addr, 32'h100);
    step(enc_r(6'h08, 0, 31, 0, 0), 0, 0);
    check("t4_jr", IR_addr, 32'h24);
    step(enc_i(6'h2b, 31, 0, 16'd4), 0, 0);
    check("t4_r31", st_data, 32'h24);

    step(enc_r(6'h2a, 5, 2, 1, 0), 0, 0);
    step(enc_r(6'h02, 6, 0, 2, 5'd28), 0, 0);
    step(enc_r(6'h20, 0, 1, 1, 0), 0, 0);
    step(enc_i(6'h2b, 5, 0, 16'd20), 0, 0);
    check("t5_slt", st_data, 32'd1);
    step(enc_i(6'h2b, 6, 0, 16'd24), 0, 0);
    check("t5_srl", st_data, 32'hF);
    step(enc_i(6'h2b, 0, 0, 16'd28), 0, 0);
    check("t5_r0", st_data, 32'd0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); r3 = 5'($urandom_range(0, 7));
      if (sel < 4) ins = enc_r(alu_fn[$urandom_range(0, 6)], r1, r2, r3, 5'($urandom_range(0, 31)));
      else if (sel == 4) ins = enc_i(6'h08, r1, r2, 16'($urandom));
      else if (sel == 5) ins = enc_i(6'h2b, r1, 0, 16'($urandom_range(0, 127) * 4));
      else if (sel == 6) ins = enc_i(6'h23, r1, 0, 16'($urandom_range(0, 127) * 4));
      else if (sel == 7) ins = enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, r1, r2, 16'($urandom_range(0, 3)));
      else if (sel == 8) ins = enc_i(nop_op[$urandom_range(0, 5)], r1, r2, 16'($urandom));
      else ins = enc_r(6'h3f, r1, r2, r3, 0);
      step(ins, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int r = 1; r < 8; r++) step(enc_i(6'h2b, 5'(r), 0, 16'(r * 4)), 0, 0);

    iwait = 0; dwait = 50; wc0 = wcount;
    imem[m_pc[11:2]] = enc_i(6'h2b, 1, 0, 16'd12);
    n = 0;
    while (CEN && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_mem_reached", CEN, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("t6_cen", CEN, 1);
    check("t6_wen", WEN, 1);
    check("t6_oen", OEN, 1);
    check("t6_imem_req", imem_req, 0);
    check("t6_ir_addr", IR_addr, 0);
    check("t6_a", A, 0);
    check("t6_data", Data2Mem, 0);
    check("t6_retire", retire, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_write", wcount, wc0);
    model_reset();
    rst_n = 1;
    #1 check("t6_rel_imem_req", imem_req, 1);
    step(enc_i(6'h2b, 1, 0, 16'd32), 0, 0);
    check("t6_rf_cleared", st_data, 32'd0);
    step(enc_i(6'h0f, 7, 0, 16'h1234), 0, 0);
    step(enc_i(6'h0d, 7, 7, 16'hFFFF), 1, 0);
    step(enc_i(6'h2b, 7, 0, 16'd36), 0, 1);
`ifdef IMM_LOGIC_EN
    check("t6_r7", st_data, 32'h1234FFFF);
`else
    check("t6_r7", st_data, 32'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
